// File: rtl/tb_uart_pkg.sv
// Shared types and helpers for the self-checking UART receiver.
package tb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned UART_CLKS_PER_BIT_25M = 217;
    localparam int unsigned MAX_EXPECTED_LEN      = 64;

    // Byte idx of a packed string; idx 0 is the most-significant byte.
    function automatic logic [7:0] exp_byte(input logic [8*MAX_EXPECTED_LEN-1:0] str,
                                            input int unsigned len,
                                            input int unsigned idx);
        logic [8:0] w_lsb;
        w_lsb = 9'(8 * (len - 1 - idx));
        return str[w_lsb +: 8];
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: two-flop synchroniser, start-edge detect, mid-bit sampling FSM.
module uart_rx_core
    import tb_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_25M
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam logic [15:0] HalfLoad = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullLoad = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  r_sync;
    logic        r_rxd_d;
    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_byte_valid;
    logic [7:0]  r_byte_data;
    logic        r_frame_err;

    logic w_rxd_s;
    logic w_fall;
    logic w_expire;

    assign w_rxd_s  = r_sync[1];
    assign w_fall   = r_rxd_d & ~w_rxd_s;
    assign w_expire = (r_cnt == 16'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync       <= 2'b11;
            r_rxd_d      <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rxd};
            r_rxd_d      <= w_rxd_s;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= HalfLoad;
                    end
                end
                START: begin
                    if (w_expire) begin
                        // A high line at mid-start-bit means the edge was a glitch.
                        if (w_rxd_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                            r_cnt     <= FullLoad;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (w_expire) begin
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        r_cnt   <= FullLoad;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (w_expire) begin
                        if (w_rxd_s) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                BREAK: begin
                    if (w_rxd_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_rx_checker.sv
// UART receive checker: compares received bytes to an expected string and
// reports sticky pass/fail/timeout status.
module uart_rx_checker
    import tb_uart_pkg::*;
#(
    parameter int unsigned               CLKS_PER_BIT = UART_CLKS_PER_BIT_25M,
    parameter int unsigned               EXPECTED_LEN = 8,
    parameter logic [8*EXPECTED_LEN-1:0] EXPECTED     = "F1F2F3DN",
    parameter int unsigned               TIMEOUT_CLKS = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic [7:0] byte_count,
    output logic       mismatch,
    output logic [5:0] mismatch_idx,
    output logic       done,
    output logic       pass,
    output logic       timeout
);

    if (EXPECTED_LEN > MAX_EXPECTED_LEN || EXPECTED_LEN == 0) begin : g_len_check
        $error("uart_rx_checker: EXPECTED_LEN must be in 1..64");
    end

    localparam logic [8*MAX_EXPECTED_LEN-1:0] ExpStr  = (8 * MAX_EXPECTED_LEN)'(EXPECTED);
    localparam logic [7:0]                    ExpLen8 = 8'(EXPECTED_LEN);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;
    logic [7:0] w_exp;

    logic [7:0]  r_count;
    logic        r_mismatch;
    logic [5:0]  r_mismatch_idx;
    logic        r_done;
    logic        r_ferr_seen;
    logic        r_extra;
    logic        r_timeout;
    logic [31:0] r_cyc;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rxd        (rxd),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    assign w_exp = exp_byte(ExpStr, EXPECTED_LEN, 32'(r_count));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= 8'd0;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= 6'd0;
            r_done         <= 1'b0;
            r_ferr_seen    <= 1'b0;
            r_extra        <= 1'b0;
            r_timeout      <= 1'b0;
            r_cyc          <= 32'd0;
        end else begin
            if (w_byte_valid) begin
                if (r_count < ExpLen8) begin
                    if (!r_mismatch && (w_byte_data != w_exp)) begin
                        r_mismatch     <= 1'b1;
                        r_mismatch_idx <= r_count[5:0];
                    end
                end else begin
                    r_extra <= 1'b1;
                end
                if (r_count != 8'hFF) begin
                    r_count <= r_count + 8'd1;
                end
                if ((r_count + 8'd1) == ExpLen8) begin
                    r_done <= 1'b1;
                end
            end
            if (w_frame_err) begin
                r_ferr_seen <= 1'b1;
            end
            // Cycle counter freezes once the run has resolved either way.
            if (!r_done && !r_timeout) begin
                r_cyc <= r_cyc + 32'd1;
                if ((r_cyc + 32'd1) == TIMEOUT_CLKS) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign byte_valid   = w_byte_valid;
    assign byte_data    = w_byte_data;
    assign frame_err    = w_frame_err;
    assign byte_count   = r_count;
    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
    assign done         = r_done;
    assign pass         = r_done & ~r_mismatch & ~r_ferr_seen & ~r_extra;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Scenario bench for uart_rx_checker: serial stimulus with a byte scoreboard.
module tb_uart_rx_checker;
    import tb_uart_pkg::*;

    localparam int unsigned CPB = 217;
    localparam int unsigned TO  = 10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic [7:0] byte_count;
    logic       mismatch;
    logic [5:0] mismatch_idx;
    logic       done;
    logic       pass;
    logic       timeout;

    uart_rx_checker #(
        .CLKS_PER_BIT (CPB),
        .EXPECTED_LEN (8),
        .EXPECTED     ("F1F2F3DN"),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .frame_err    (frame_err),
        .byte_count   (byte_count),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_bv = 0;
    int n_ferr = 0;
    int last_bv_cyc = -1;
    int done_rise_cyc = -1;
    logic prev_done = 1'b0;
    logic [7:0] exp_q[$];

    // One clock step; byte outputs are popped against the scoreboard here.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (frame_err) n_ferr++;
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
        if (byte_valid) begin
            n_bv++;
            last_bv_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL byte_unexpected: got 0x%02h, required no byte", byte_data);
            end else begin
                e = exp_q.pop_front();
                if (byte_data !== e) begin
                    n_errors++;
                    $display("FAIL byte_data: got 0x%02h, required 0x%02h", byte_data, e);
                end
            end
        end
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit push);
        if (push) exp_q.push_back(b);
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rxd = stop_bit;
        hold(CPB);
        rxd = 1'b1;
    endtask

    task automatic send_str8(input logic [63:0] s);
        for (int i = 0; i < 8; i++) begin
            send_byte(s[63-8*i -: 8], 1'b1, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        hold(2);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        rst = 1'b1;
        rxd = 1'b1;
        hold(3);
        obs = {byte_valid, byte_data, frame_err, byte_count, mismatch, mismatch_idx,
               done, pass, timeout};
        n_checks++;
        if (obs !== 28'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got 0x%07h, required 0x0000000", obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_two_bytes();
        int bv0;
        do_reset();
        bv0 = n_bv;
        send_byte(8'h46, 1'b1, 1'b1);
        send_byte(8'h31, 1'b1, 1'b1);
        hold(CPB);
        n_checks++;
        if (n_bv - bv0 !== 2) begin
            n_errors++;
            $display("FAIL two_bytes_valid: got %0d pulses, required 2", n_bv - bv0);
        end
        n_checks++;
        if (byte_count !== 8'd2 || mismatch !== 1'b0) begin
            n_errors++;
            $display("FAIL two_bytes_status: got count=%0d mismatch=%b, required 2/0",
                     byte_count, mismatch);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL two_bytes_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        done_rise_cyc = -1;
        send_str8("F1F2F3DN");
        hold(20);
        n_checks++;
        if (byte_count !== 8'd8 || done !== 1'b1 || pass !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_status: got count=%0d done=%b pass=%b, required 8/1/1",
                     byte_count, done, pass);
        end
        n_checks++;
        if (done_rise_cyc !== last_bv_cyc + 1) begin
            n_errors++;
            $display("FAIL b2b_done_latency: got cycle %0d, required %0d",
                     done_rise_cyc, last_bv_cyc + 1);
        end
    endtask

    task automatic test_glitch();
        int bv0;
        int f0;
        do_reset();
        bv0 = n_bv;
        f0 = n_ferr;
        rxd = 1'b0;
        hold(50);
        rxd = 1'b1;
        hold(400);
        n_checks++;
        if (n_bv !== bv0 || n_ferr !== f0 || byte_count !== 8'd0) begin
            n_errors++;
            $display("FAIL glitch_quiet: got bv=%0d ferr=%0d count=%0d, required 0/0/0",
                     n_bv - bv0, n_ferr - f0, byte_count);
        end
        n_checks++;
        if (dut.u_core.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL glitch_state: got %0d, required IDLE", dut.u_core.r_state);
        end
        send_byte(8'h46, 1'b1, 1'b1);
        hold(10);
        n_checks++;
        if (byte_count !== 8'd1) begin
            n_errors++;
            $display("FAIL glitch_recover: got count=%0d, required 1", byte_count);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        send_str8("F1F2F4DN");
        hold(20);
        n_checks++;
        if (mismatch !== 1'b1 || mismatch_idx !== 6'd5) begin
            n_errors++;
            $display("FAIL mismatch_flag: got mismatch=%b idx=%0d, required 1/5",
                     mismatch, mismatch_idx);
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            n_errors++;
            $display("FAIL mismatch_done: got done=%b pass=%b, required 1/0", done, pass);
        end
        send_byte(8'h58, 1'b1, 1'b1);
        hold(20);
        n_checks++;
        if (byte_count !== 8'd9 || pass !== 1'b0 || mismatch_idx !== 6'd5) begin
            n_errors++;
            $display("FAIL extra_byte: got count=%0d pass=%b idx=%0d, required 9/0/5",
                     byte_count, pass, mismatch_idx);
        end
    endtask

    task automatic test_frame_err();
        int bv0;
        int f0;
        do_reset();
        bv0 = n_bv;
        f0 = n_ferr;
        send_byte(8'h46, 1'b0, 1'b0);
        hold(CPB);
        n_checks++;
        if (n_ferr - f0 !== 1 || n_bv !== bv0 || byte_count !== 8'd0) begin
            n_errors++;
            $display("FAIL frame_err_pulse: got ferr=%0d bv=%0d count=%0d, required 1/0/0",
                     n_ferr - f0, n_bv - bv0, byte_count);
        end
        send_str8("F1F2F3DN");
        hold(20);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || mismatch !== 1'b0 || byte_count !== 8'd8) begin
            n_errors++;
            $display("FAIL frame_err_sticky: got done=%b pass=%b mm=%b count=%0d, required 1/0/0/8",
                     done, pass, mismatch, byte_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [27:0] obs;
        int bv0;
        logic [7:0] b;
        b = 8'h46;
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rst = 1'b1;
        rxd = 1'b1;
        tick();
        rst = 1'b0;
        obs = {byte_valid, byte_data, frame_err, byte_count, mismatch, mismatch_idx,
               done, pass, timeout};
        n_checks++;
        if (obs !== 28'd0) begin
            n_errors++;
            $display("FAIL midframe_reset_outputs: got 0x%07h, required 0x0000000", obs);
        end
        bv0 = n_bv;
        hold(2 * CPB);
        n_checks++;
        if (n_bv !== bv0 || dut.u_core.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL midframe_discard: got bv=%0d state=%0d, required 0/IDLE",
                     n_bv - bv0, dut.u_core.r_state);
        end
        send_byte(8'h46, 1'b1, 1'b1);
        hold(10);
        n_checks++;
        if (byte_count !== 8'd1 || mismatch !== 1'b0 || n_bv - bv0 !== 1) begin
            n_errors++;
            $display("FAIL midframe_next: got count=%0d mm=%b bv=%0d, required 1/0/1",
                     byte_count, mismatch, n_bv - bv0);
        end
    endtask

    task automatic test_timeout();
        int c0;
        do_reset();
        c0 = cyc;
        send_byte(8'h46, 1'b1, 1'b1);
        send_byte(8'h31, 1'b1, 1'b1);
        hold(c0 + int'(TO) - 1 - cyc);
        n_checks++;
        if (timeout !== 1'b0 || done !== 1'b0 || byte_count !== 8'd2) begin
            n_errors++;
            $display("FAIL timeout_early: got to=%b done=%b count=%0d, required 0/0/2",
                     timeout, done, byte_count);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_edge: got %b, required 1", timeout);
        end
        hold(5);
        n_checks++;
        if (timeout !== 1'b1 || pass !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_sticky: got to=%b pass=%b, required 1/0", timeout, pass);
        end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_back_to_back();
        test_glitch();
        test_mismatch();
        test_frame_err();
        test_reset_mid_frame();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
